// File: rtl/ultrasonic_echo_emulator_pkg.sv
// Shared definitions for the ultrasonic ranger emulator and its sensor controller.
// Contents: FSM state enum, default timing constants (50 MHz clocks), counter width.
// No ports; imported with ultrasonic_pkg::*.
package ultrasonic_pkg;

   localparam int CNT_W           = 28;
   localparam int MIN_TRIG_CYCLES = 500;
   localparam int BURST_CYCLES    = 10000;
   localparam int CYCLES_PER_CM   = 2900;
   localparam int MAX_CM          = 400;
   localparam int TIMEOUT_CYCLES  = 1900000;
   localparam int HOLDOFF_CYCLES  = 50000;
   localparam int JITTER_BITS     = 4;

   typedef enum logic [2:0] {
      IDLE,
      TRIG_HI,
      BURST,
      ECHO,
      HOLDOFF
   } state_t;

endpackage

// File: rtl/ultrasonic_echo_emulator_if.sv
// Pin-level bundle between a sensor controller (master) and the ranger emulator (slave).
// master drives trig and distance_cm; slave drives echo, busy, trig_err, meas_count.
// Purely combinational grouping, no clock inside.
interface ultrasonic_echo_emulator_if;
   logic        trig;
   logic [15:0] distance_cm;
   logic        echo;
   logic        busy;
   logic        trig_err;
   logic [15:0] meas_count;

   modport master (output trig, distance_cm, input echo, busy, trig_err, meas_count);
   modport slave  (input trig, distance_cm, output echo, busy, trig_err, meas_count);
endinterface

// File: rtl/ultrasonic_echo_emulator_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out, 2-clock lag).
// Both flops clear on reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04-style ranger model: trig pulse in, echo pulse out whose width encodes distance_cm.
// Ports: clk50, rst (sync, active-high), bus (slave modport: trig, distance_cm, echo, busy, trig_err, meas_count).
// Optional: define ULTRASONIC_ECHO_JITTER_EN to add LFSR jitter to normal echo widths.
module ultrasonic_echo_emulator #(
   parameter int MIN_TRIG_CYCLES = ultrasonic_pkg::MIN_TRIG_CYCLES,
   parameter int BURST_CYCLES    = ultrasonic_pkg::BURST_CYCLES,
   parameter int CYCLES_PER_CM   = ultrasonic_pkg::CYCLES_PER_CM,
   parameter int MAX_CM          = ultrasonic_pkg::MAX_CM,
   parameter int TIMEOUT_CYCLES  = ultrasonic_pkg::TIMEOUT_CYCLES,
   parameter int HOLDOFF_CYCLES  = ultrasonic_pkg::HOLDOFF_CYCLES
) (
   input  logic                        clk50,
   input  logic                        rst,
   ultrasonic_echo_emulator_if.slave   bus
);
   import ultrasonic_pkg::*;

   localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_TRIG_CYCLES);
   localparam logic [CNT_W-1:0] BURST_END = CNT_W'(BURST_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] echo_len, echo_len_nxt;
   logic [15:0]      latched_cm, latched_cm_nxt;
   logic [15:0]      meas_count;
   logic             trig_s, trig_s_q;
   logic             trig_err_q, trig_err_nxt;
   logic             meas_inc;
   logic             normal;
   logic [CNT_W-1:0] len_base, jitter;

   sync_2ff u_sync (
      .clk (clk50),
      .rst (rst),
      .d   (bus.trig),
      .q   (trig_s)
   );

   // Zero and anything beyond MAX_CM behave like "no target": long timeout echo.
   assign normal   = (latched_cm != 16'd0) && (latched_cm <= 16'(MAX_CM));
   assign len_base = normal ? (CNT_W'(latched_cm) * CNT_W'(CYCLES_PER_CM)) : TIMEOUT_C;

`ifdef ULTRASONIC_ECHO_JITTER_EN
   logic [15:0] lfsr;

   // Galois form of x^16+x^14+x^13+x^11+1, free-running.
   always_ff @(posedge clk50) begin
      if (rst) lfsr <= 16'hACE1;
      else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   assign jitter = CNT_W'(lfsr[JITTER_BITS-1:0]);
`else
   assign jitter = '0;
`endif

   always_ff @(posedge clk50) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         echo_len   <= '0;
         latched_cm <= '0;
         trig_s_q   <= 1'b0;
         trig_err_q <= 1'b0;
         meas_count <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         echo_len   <= echo_len_nxt;
         latched_cm <= latched_cm_nxt;
         trig_s_q   <= trig_s;
         trig_err_q <= trig_err_nxt;
         meas_count <= meas_count + {15'd0, meas_inc};
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      echo_len_nxt   = echo_len;
      latched_cm_nxt = latched_cm;
      trig_err_nxt   = 1'b0;
      meas_inc       = 1'b0;
      case (state)
         IDLE: begin
            // trig_s_q tracks trig_s in every state, so a level still high
            // when HOLDOFF ends is not seen as a new rising edge.
            if (trig_s && !trig_s_q) begin
               state_nxt = TRIG_HI;
               cnt_nxt   = ONE;
            end
         end
         TRIG_HI: begin
            if (trig_s) begin
               if (cnt < MIN_C) cnt_nxt = cnt + ONE;
            end else if (cnt >= MIN_C) begin
               state_nxt      = BURST;
               cnt_nxt        = '0;
               latched_cm_nxt = bus.distance_cm;
            end else begin
               state_nxt    = IDLE;
               cnt_nxt      = '0;
               trig_err_nxt = 1'b1;
            end
         end
         BURST: begin
            echo_len_nxt = len_base;
            if (cnt == BURST_END) begin
               state_nxt    = ECHO;
               cnt_nxt      = '0;
               echo_len_nxt = normal ? (len_base + jitter) : len_base;
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
         ECHO: begin
            if (cnt == echo_len - ONE) begin
               state_nxt = HOLDOFF;
               cnt_nxt   = '0;
               meas_inc  = 1'b1;
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
         HOLDOFF: begin
            if (cnt == HOLD_END) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign bus.echo       = (state == ECHO);
   assign bus.busy       = (state != IDLE);
   assign bus.trig_err   = trig_err_q;
   assign bus.meas_count = meas_count;
endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed bench for ultrasonic_echo_emulator using scaled-down timing parameters.
// Drives trig/distance_cm through the interface, checks echo delay, width, trig_err, busy, meas_count.
// Table of vectors plus hand sequences for holdoff, reset mid-echo and jitter.
module tb_ultrasonic_echo_emulator;
   localparam int T_MIN   = 5;
   localparam int T_BURST = 20;
   localparam int T_CPC   = 3;
   localparam int T_MAX   = 40;
   localparam int T_TMO   = 200;
   localparam int T_HOLD  = 50;
   localparam int WIN     = 1000;

   logic clk50 = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   ultrasonic_echo_emulator_if bif ();

   ultrasonic_echo_emulator #(
      .MIN_TRIG_CYCLES (T_MIN),
      .BURST_CYCLES    (T_BURST),
      .CYCLES_PER_CM   (T_CPC),
      .MAX_CM          (T_MAX),
      .TIMEOUT_CYCLES  (T_TMO),
      .HOLDOFF_CYCLES  (T_HOLD)
   ) dut (
      .clk50 (clk50),
      .rst   (rst),
      .bus   (bif)
   );

   always #5 clk50 = ~clk50;

   typedef struct {
      int          trig_len;
      logic [15:0] cm;
      int          exp_delay;
      int          exp_width;
      int          exp_errs;
      int          exp_count;
      bit          jit;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk50);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s actual=%0d expected=[%0d,%0d]", name, act, lo, hi);
      end
   endtask

   // Pulse trig for trig_len clocks, then watch a fixed window after the fall.
   // delay = clocks from the first edge seeing trig low to the edge raising echo.
   task automatic run_meas(input int trig_len, input logic [15:0] cm,
                           output int delay, output int width, output int errs,
                           output int busy3, output int busy_end);
      delay = -1; width = 0; errs = 0; busy3 = -1;
      bif.distance_cm = cm;
      bif.trig = 1'b1;
      repeat (trig_len) tick();
      bif.trig = 1'b0;
      for (int j = 0; j < WIN; j++) begin
         tick();
         if (j == 5) bif.distance_cm = cm ^ 16'h5A5A;
         if (j == 2) busy3 = int'(bif.busy);
         if (bif.echo) begin
            if (delay < 0) delay = j;
            width++;
         end
         if (bif.trig_err) errs++;
      end
      busy_end = int'(bif.busy);
   endtask

   int d, w, e, b3, be, t, cnt0, wmin, wmax;
   bit ok;

   initial begin
      //           len  cm        delay        width          errs count jit
      vecs[0] = '{6,   16'd10,   2 + T_BURST, 30,            0,   1,    1'b1};
      vecs[1] = '{3,   16'd10,   -1,          0,             1,   1,    1'b0};
      vecs[2] = '{5,   16'd40,   2 + T_BURST, 120,           0,   2,    1'b1};
      vecs[3] = '{4,   16'd5,    -1,          0,             1,   2,    1'b0};
      vecs[4] = '{6,   16'd0,    2 + T_BURST, T_TMO,         0,   3,    1'b0};
      vecs[5] = '{6,   16'd41,   2 + T_BURST, T_TMO,         0,   4,    1'b0};
      vecs[6] = '{6,   16'd1,    2 + T_BURST, 3,             0,   5,    1'b1};
      vecs[7] = '{6,   16'hFFFF, 2 + T_BURST, T_TMO,         0,   6,    1'b0};

      rst = 1'b1;
      bif.trig = 1'b0;
      bif.distance_cm = 16'd0;
      repeat (3) tick();
      chk("reset_echo", int'(bif.echo), 0);
      chk("reset_busy", int'(bif.busy), 0);
      chk("reset_trig_err", int'(bif.trig_err), 0);
      chk("reset_meas_count", int'(bif.meas_count), 0);
      rst = 1'b0;
      repeat (3) tick();

      foreach (vecs[i]) begin
         run_meas(vecs[i].trig_len, vecs[i].cm, d, w, e, b3, be);
         if (vecs[i].exp_width > 0) chk($sformatf("v%0d_delay", i), d, vecs[i].exp_delay);
         else                       chk($sformatf("v%0d_busy3", i), b3, 0);
`ifdef ULTRASONIC_ECHO_JITTER_EN
         if (vecs[i].jit) chk_range($sformatf("v%0d_width", i), w, vecs[i].exp_width, vecs[i].exp_width + 15);
         else             chk($sformatf("v%0d_width", i), w, vecs[i].exp_width);
`else
         chk($sformatf("v%0d_width", i), w, vecs[i].exp_width);
`endif
         chk($sformatf("v%0d_errs", i), e, vecs[i].exp_errs);
         chk($sformatf("v%0d_count", i), int'(bif.meas_count), vecs[i].exp_count);
         chk($sformatf("v%0d_busy_end", i), be, 0);
      end

      // Triggers inside HOLDOFF, and one held high across HOLDOFF exit, are ignored.
      cnt0 = int'(bif.meas_count);
      bif.distance_cm = 16'd10;
      bif.trig = 1'b1;
      repeat (6) tick();
      bif.trig = 1'b0;
      ok = 1'b0;
      for (int j = 0; j < 500 && !ok; j++) begin
         tick();
         if (bif.echo) ok = 1'b1;
      end
      chk("holdoff_echo_rise_seen", int'(ok), 1);
      ok = 1'b0;
      for (int j = 0; j < 500 && !ok; j++) begin
         tick();
         if (!bif.echo) ok = 1'b1;
      end
      chk("holdoff_echo_fall_seen", int'(ok), 1);
      e = 0; w = 0;
      for (int j = 1; j < 150; j++) begin
         bif.trig = ((j >= 10 && j < 16) || (j >= 40 && j < 70)) ? 1'b1 : 1'b0;
         tick();
         if (bif.echo) w++;
         if (bif.trig_err) e++;
      end
      bif.trig = 1'b0;
      chk("holdoff_no_echo", w, 0);
      chk("holdoff_no_err", e, 0);
      chk("holdoff_count", int'(bif.meas_count), cnt0 + 1);
      chk("holdoff_idle", int'(bif.busy), 0);
      run_meas(6, 16'd10, d, w, e, b3, be);
      chk("after_holdoff_delay", d, 2 + T_BURST);
`ifndef ULTRASONIC_ECHO_JITTER_EN
      chk("after_holdoff_width", w, 30);
`endif
      chk("after_holdoff_count", int'(bif.meas_count), cnt0 + 2);

      // Reset in the middle of an echo.
      bif.distance_cm = 16'd40;
      bif.trig = 1'b1;
      repeat (6) tick();
      bif.trig = 1'b0;
      ok = 1'b0;
      for (int j = 0; j < 500 && !ok; j++) begin
         tick();
         if (bif.echo) ok = 1'b1;
      end
      chk("rst_mid_echo_rise_seen", int'(ok), 1);
      repeat (20) tick();
      rst = 1'b1;
      tick();
      chk("rst_mid_echo", int'(bif.echo), 0);
      chk("rst_mid_busy", int'(bif.busy), 0);
      chk("rst_mid_count", int'(bif.meas_count), 0);
      rst = 1'b0;
      repeat (3) tick();
      run_meas(6, 16'd20, d, w, e, b3, be);
      chk("post_rst_delay", d, 2 + T_BURST);
`ifndef ULTRASONIC_ECHO_JITTER_EN
      chk("post_rst_width", w, 60);
`endif
      chk("post_rst_count", int'(bif.meas_count), 1);

`ifdef ULTRASONIC_ECHO_JITTER_EN
      wmin = 1 << 30; wmax = 0;
      for (int r = 0; r < 20; r++) begin
         run_meas(6, 16'd10, d, w, e, b3, be);
         chk_range($sformatf("jit_run%0d_width", r), w, 30, 45);
         if (w < wmin) wmin = w;
         if (w > wmax) wmax = w;
      end
      chk("jit_widths_vary", int'(wmax != wmin), 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      t = 0;
      #2000000;
      $display("FAIL global_timeout actual=expired expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ultrasonic_echo_emulator.md
Name: ultrasonic_echo_emulator

Overview:
- Cycle-accurate model of an HC-SR04-style ultrasonic ranger, for hardware-in-the-loop and board bring-up of the mobility board.
- Accepts the trigger pulse that the sensor controller drives, waits a fixed burst delay, then returns an echo pulse whose width encodes a distance supplied on a port.
- Replaces the physical sensor on the FPGA pins. Out-of-range and invalid triggers are modelled exactly as the real part handles them.

Parameters:
- MIN_TRIG_CYCLES, 500: minimum synchronized trig high time (10 us at 50 MHz) for a valid trigger.
- BURST_CYCLES, 10000: delay from trig fall to echo rise (200 us, 8-cycle 40 kHz burst).
- CYCLES_PER_CM, 2900: echo-high clocks per cm (58 us/cm).
- MAX_CM, 400: largest distance that produces a normal echo.
- TIMEOUT_CYCLES, 1900000: echo-high clocks for no-target or out-of-range (38 ms).
- HOLDOFF_CYCLES, 50000: dead time after echo falls before a new trig is accepted (1 ms).
- JITTER_BITS, 4: width of the jitter term (optional feature only).

Ports:
- clk50 input 1: 50 MHz system clock.
- rst input 1: synchronous, active-high reset.
- trig input 1: trigger from the controller (sensor_trig side); asynchronous to clk50.
- distance_cm input 16: simulated target distance; sampled once per measurement.
- echo output 1: echo pulse to the controller (sensor_echo side).
- busy output 1: high in every state except IDLE.
- trig_err output 1: one-cycle pulse when a trigger is rejected for being too short.
- meas_count output 16: count of echoes completed (normal and timeout); wraps.

Behaviour:
- Reset: synchronous, active-high. All outputs clear to 0: echo, busy, trig_err, meas_count. FSM goes to IDLE, counter clears, synchronizer flops clear. Reset mid-echo drops echo on the next edge.
- trig passes through a 2-flop synchronizer, giving trig_s. All timing below counts from trig_s edges, which lag the pin by 2 clocks.
- Internal counter is 28 bits unsigned and never wraps during a measurement.
- IDLE:
  - On trig_s rise: go to TRIG_HI and set counter to 1.
- TRIG_HI:
  - While trig_s is high: counter increments and saturates at MIN_TRIG_CYCLES.
  - On trig_s fall with counter >= MIN_TRIG_CYCLES: latch distance_cm and go to BURST with counter = 0.
  - On trig_s fall with counter < MIN_TRIG_CYCLES: pulse trig_err for 1 cycle and return to IDLE.
- BURST:
  - Counts BURST_CYCLES clocks, then goes to ECHO.
  - echo asserts on the first ECHO cycle.
  - Echo length L:
    - L = latched_cm * CYCLES_PER_CM when 1 <= latched_cm <= MAX_CM.
    - L = TIMEOUT_CYCLES when latched_cm == 0 or latched_cm > MAX_CM.
  - L is computed in BURST as a registered 28-bit product.
- ECHO:
  - echo stays high for exactly L clocks, then goes low.
  - On exit, meas_count increments and the FSM enters HOLDOFF.
- HOLDOFF:
  - Counts HOLDOFF_CYCLES clocks, then returns to IDLE.
  - trig_s activity here is ignored: no trig_err, no re-arm. A trig_s already high on HOLDOFF exit is not a rising edge and does not start a measurement.
- trig edges during BURST or ECHO are ignored.
- distance_cm changes after the latch point have no effect on the measurement in progress.
- meas_count wraps from 0xFFFF to 0.

Optional Feature:
- Macro: ULTRASONIC_ECHO_JITTER_EN.
- When defined: a 16-bit Galois LFSR (poly x^16+x^14+x^13+x^11+1, seed 0xACE1 on rst) steps once per clock. Its low JITTER_BITS bits, sampled on entry to ECHO, are added to L for normal echoes only; timeout echoes are not jittered.
- When undefined: no LFSR and L is exact.

Decomposition:
- Shared package ultrasonic_pkg holds:
  - the FSM state enum: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF;
  - the timing constants above;
  - the 28-bit counter width constant.
- The sensor controller uses the same package.
- One sub-module, sync_2ff, is the generic 2-flop synchronizer.

Test Plan:
- 600-clock trig, distance_cm=100 -> echo rises 2+10000 clocks after trig falls at the pin; high exactly 290000 clocks; meas_count=1.
- 300-clock trig -> one trig_err pulse, echo stays 0, busy back to 0 within 3 clocks of the fall.
- distance_cm=0, then a separate run with 401 -> echo high 1900000 clocks in each case.
- Second trig issued 10000 clocks after echo falls (inside HOLDOFF) -> ignored, no trig_err; a trig issued after holdoff completes is measured normally.
- rst asserted mid-ECHO with distance 200 -> echo, busy, meas_count all 0 the next cycle; a following valid trig measures normally.
- ULTRASONIC_ECHO_JITTER_EN defined, distance 10 for 20 runs -> every width in [29000, 29015], and not all widths equal.
